// File: rtl/debouncer_array_pkg.sv
// Shared definitions for the debouncer array: event-mode encodings and the
// helper that sizes each channel's qualification counter.
package debouncer_array_pkg;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_BOTH = 2;

  // Counter width needed to count 0..ticks-1, never narrower than one bit.
  function automatic int cnt_width(input int ticks);
    int w;
    w = $clog2(ticks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debouncer_array_channel.sv
// One debounce channel: input synchroniser, run-length qualification counter,
// debounced level register, rise/fall pulses and sticky pending flag.
module debounce_channel
  import debouncer_array_pkg::*;
#(
  parameter int   STABLE_TICKS = 16,
  parameter int   SYNC_STAGES  = 2,
  parameter logic INIT_LEVEL   = 1'b0,
  parameter int   EVENT_MODE   = EV_BOTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic din,
  input  logic ack,
  output logic db_level,
  output logic rise,
  output logic fall,
  output logic pending,
  output logic pending_next
);

  localparam int             CW      = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_next;
  logic                   mismatch;
  logic                   accept;
  logic                   set_pending;

  assign sync_out = sync[SYNC_STAGES-1];

  // Synchroniser chain; resets to the initial level so release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  // Qualification: count consecutive mismatching ticks, accept on the last one, any match restarts.
  always_comb begin
    mismatch    = (sync_out != db_level);
    accept      = clk_en && mismatch && (cnt == CNT_MAX);
    cnt_next    = cnt;
    set_pending = 1'b0;
    if (clk_en) begin
      if (!mismatch || accept) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
    if (EVENT_MODE == EV_RISE) begin
      set_pending = accept && sync_out;
    end else if (EVENT_MODE == EV_FALL) begin
      set_pending = accept && !sync_out;
    end else begin
      set_pending = accept;
    end
    pending_next = set_pending || (pending && !ack);
  end

  // State update: counter, level, single-cycle edge pulses and the sticky flag (set beats ack).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      db_level <= INIT_LEVEL;
      rise     <= 1'b0;
      fall     <= 1'b0;
      pending  <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      db_level <= accept ? sync_out : db_level;
      rise     <= accept && sync_out;
      fall     <= accept && !sync_out;
      pending  <= pending_next;
    end
  end

endmodule

// File: rtl/debouncer_array.sv
// Multi-channel debouncer: independent debounce channels sharing clock, reset
// and sampling tick, plus a registered interrupt summarising pending events.
module debouncer_array
  import debouncer_array_pkg::*;
#(
  parameter int                  CHANNELS     = 4,
  parameter int                  STABLE_TICKS = 16,
  parameter int                  SYNC_STAGES  = 2,
  parameter logic [CHANNELS-1:0] INIT_LEVEL   = '0,
  parameter int                  EVENT_MODE   = EV_BOTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic [CHANNELS-1:0] din,
  input  logic [CHANNELS-1:0] ack,
  output logic [CHANNELS-1:0] db_level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] pending,
  output logic                irq
);

  logic [CHANNELS-1:0] pending_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .SYNC_STAGES  (SYNC_STAGES),
      .INIT_LEVEL   (INIT_LEVEL[i]),
      .EVENT_MODE   (EVENT_MODE)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .clk_en       (clk_en),
      .din          (din[i]),
      .ack          (ack[i]),
      .db_level     (db_level[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .pending      (pending[i]),
      .pending_next (pending_next[i])
    );
  end

  // Interrupt follows the next-state of the pending flags so it lines up with them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |pending_next;
    end
  end

endmodule

// File: tb/tb_debouncer_array.sv
// Randomised scoreboard bench for debouncer_array with a behavioural reference model.
module tb_debouncer_array;

  localparam int       CH   = 4;
  localparam int       ST   = 4;
  localparam int       SS   = 2;
  localparam int       MODE = 0;
  localparam logic [3:0] INIT = 4'b0101;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] pend;
    logic       irq;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic [3:0] din = INIT;
  logic [3:0] ack = 4'b0000;
  logic [3:0] db_level, rise, fall, pending;
  logic       irq;

  int errors = 0;
  int checks = 0;

  exp_t exp_q[$];

  // Reference model state: delayed input samples, debounced level, run lengths.
  logic [3:0] sync_q[$];
  logic [3:0] m_level, m_rise, m_fall, m_pend;
  logic       m_irq;
  int         run[CH];

  debouncer_array #(
    .CHANNELS     (CH),
    .STABLE_TICKS (ST),
    .SYNC_STAGES  (SS),
    .INIT_LEVEL   (INIT),
    .EVENT_MODE   (MODE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .din      (din),
    .ack      (ack),
    .db_level (db_level),
    .rise     (rise),
    .fall     (fall),
    .pending  (pending),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    sync_q.delete();
    for (int i = 0; i < SS; i++) sync_q.push_front(INIT);
    m_level = INIT;
    m_rise  = '0;
    m_fall  = '0;
    m_pend  = '0;
    m_irq   = 1'b0;
    for (int c = 0; c < CH; c++) run[c] = 0;
  endtask

  // One clock edge of behaviour: input seen SS edges late, level flips after ST mismatching ticks.
  task automatic model_edge(input logic [3:0] d, input logic [3:0] a, input logic en);
    logic [3:0] seen;
    logic       acc, setp;
    seen = sync_q[$];
    void'(sync_q.pop_back());
    sync_q.push_front(d);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < CH; c++) begin
      acc = 1'b0;
      if (en) begin
        if (seen[c] != m_level[c]) begin
          run[c] = run[c] + 1;
          if (run[c] == ST) begin
            acc        = 1'b1;
            run[c]     = 0;
            m_level[c] = seen[c];
          end
        end else begin
          run[c] = 0;
        end
      end
      if (acc && seen[c])  m_rise[c] = 1'b1;
      if (acc && !seen[c]) m_fall[c] = 1'b1;
      setp = acc && ((MODE == 2) || (MODE == 0 && seen[c]) || (MODE == 1 && !seen[c]));
      if (setp)        m_pend[c] = 1'b1;
      else if (a[c])   m_pend[c] = 1'b0;
    end
    m_irq = |m_pend;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Called at posedge+1: drive inputs, push the expected outputs for this cycle, take the edge.
  task automatic applyStimulus(input logic [3:0] d, input logic [3:0] a, input logic en, input logic r);
    exp_t e;
    din    = d;
    ack    = a;
    clk_en = en;
    rst    = r;
    if (r) model_reset();
    e.level = m_level;
    e.rise  = m_rise;
    e.fall  = m_fall;
    e.pend  = m_pend;
    e.irq   = m_irq;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) model_edge(d, a, en);
    #1;
  endtask

  // Monitor: every falling edge pops one expectation and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("db_level", db_level, e.level);
        checkOutput("rise", rise, e.rise);
        checkOutput("fall", fall, e.fall);
        checkOutput("pending", pending, e.pend);
        checkOutput("irq", {3'b000, irq}, {3'b000, e.irq});
      end
    end
  end

  initial begin
    logic [3:0] d;
    logic [3:0] a;
    int         found;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(INIT, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(INIT, 4'b0000, 1'b1, 1'b0);

    // Clean edge on channel 1: rise expected on edge SS+ST-1.
    found = -1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(INIT | 4'b0010, 4'b0000, 1'b1, 1'b0);
      if (rise[1] === 1'b1 && found < 0) found = k;
    end
    checks++;
    if (found != SS + ST - 1) begin
      errors++;
      $display("[TB] FAIL latency_rise1: got edge %0d expected edge %0d", found, SS + ST - 1);
    end
    applyStimulus(INIT | 4'b0010, 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(INIT | 4'b0010, 4'b0000, 1'b1, 1'b0);

    // Glitch on channel 3: three highs, one low, then held high.
    d = INIT | 4'b0010;
    for (int i = 0; i < 3; i++) applyStimulus(d | 4'b1000, 4'b0000, 1'b1, 1'b0);
    applyStimulus(d, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(d | 4'b1000, 4'b0000, 1'b1, 1'b0);
    d = d | 4'b1000;

    // Gated tick: clk_en one cycle in eight, channel 2 released then pressed.
    for (int i = 0; i < 64; i++) applyStimulus(d & 4'b1011, 4'b0000, (i % 8) == 7, 1'b0);
    for (int i = 0; i < 64; i++) applyStimulus(d, 4'b0000, (i % 8) == 3, 1'b0);

    // Reset in the middle of qualification, then hold the initial pattern.
    for (int i = 0; i < 3; i++) applyStimulus(~INIT, 4'b0000, 1'b1, 1'b0);
    applyStimulus(~INIT, 4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(INIT, 4'b0000, 1'b1, 1'b0);

    // Randomised traffic: slow toggling inputs, mostly-on tick, sparse acks and resets.
    d = INIT;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 9) == 0) d[c] = ~d[c];
      for (int c = 0; c < CH; c++) a[c] = ($urandom_range(0, 7) == 0);
      applyStimulus(d, a, $urandom_range(0, 3) != 0, $urandom_range(0, 599) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
